ats21: RTL and testbench



---
 rtl/ats21.sv | 255 +++++++++++++++++++++++++
 tb/tb_ats21.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ats21.sv
// ats21 - alarm/timer subsystem.
//
// Sixteen base clocks (BCs) count up by 1/2/4/8 per cycle. Twenty-four
// alarm/timer units (ATs) each watch one BC and raise a one-cycle pulse on
// their bit of `data` when that BC crosses the programmed target.
// Two clients, A and B, each deliver a 32-bit instruction as two 16-bit
// words. Both clients share one `req` strobe. If both clients hit the same
// BC, the same AT or the mode register in one cycle, client A wins.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous, active-high reset
//   req    in   1   marks the first word of an instruction on ctrlA/ctrlB
//   ctrlA  in  16   client A instruction word
//   ctrlB  in  16   client B instruction word
//   ready  out  1   1 while neither client is waiting for its second word
//   stat   out  2   one-cycle reject flags, [1] = A, [0] = B
//   data   out 24   AT expiry pulses, bit i = AT i
module ats21 (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [15:0] ctrlA,
    input  logic [15:0] ctrlB,
    output logic        ready,
    output logic [1:0]  stat,
    output logic [23:0] data
);

    localparam int NUM_BC = 16;
    localparam int NUM_AT = 24;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_SET_BC = 3'b001;
    localparam logic [2:0] OP_BC_EN  = 3'b010;
    localparam logic [2:0] OP_MODE   = 3'b011;
    localparam logic [2:0] OP_RSVD   = 3'b100;
    localparam logic [2:0] OP_ALARM  = 3'b101;
    localparam logic [2:0] OP_CDOWN  = 3'b110;
    localparam logic [2:0] OP_AT_EN  = 3'b111;

    typedef enum logic {IDLE, WORD2} cap_state_t;

    // One decoded write to a single BC.
    typedef struct packed {
        logic        load;
        logic [15:0] value;
        logic [1:0]  rate;
        logic        en_wr;
        logic        en_val;
    } bc_cmd_t;

    // One decoded write to a single AT.
    typedef struct packed {
        logic        cfg;     // alarm or countdown: reprogram, arm and enable
        logic [15:0] target;
        logic        rpt;
        logic [3:0]  bc;
        logic        en_wr;
        logic        en_val;
    } at_cmd_t;

    function automatic logic is_bc_op(input logic [2:0] op);
        return (op == OP_SET_BC) || (op == OP_BC_EN);
    endfunction

    function automatic logic is_at_op(input logic [2:0] op);
        return (op == OP_ALARM) || (op == OP_CDOWN) || (op == OP_AT_EN);
    endfunction

    // A mode write is always accepted. Every other opcode needs the block
    // to be active and the client to hold the matching permission bit.
    function automatic logic rejects(input logic [15:0] w1, input logic act,
                                     input logic at_ok, input logic bc_ok);
        logic r;
        case (w1[15:13])
            OP_MODE:                      r = 1'b0;
            OP_RSVD:                      r = 1'b1;
            OP_SET_BC, OP_BC_EN:          r = !act || !bc_ok;
            OP_ALARM, OP_CDOWN, OP_AT_EN: r = !act || !at_ok || (w1[12:8] > 5'd23);
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic bc_cmd_t bc_cmd_of(input logic [15:0] w1, input logic [15:0] w2);
        bc_cmd_t c;
        c.load   = (w1[15:13] == OP_SET_BC);
        c.value  = w2;
        c.rate   = w1[7:6];
        c.en_wr  = (w1[15:13] == OP_BC_EN);
        c.en_val = w1[7];
        return c;
    endfunction

    // `base` is the value the selected BC takes at this edge. An interval
    // of N therefore expires exactly N increments after the instruction.
    function automatic at_cmd_t at_cmd_of(input logic [15:0] w1, input logic [15:0] w2,
                                          input logic [15:0] base);
        at_cmd_t c;
        c.cfg    = (w1[15:13] == OP_ALARM) || (w1[15:13] == OP_CDOWN);
        c.target = (w1[15:13] == OP_CDOWN) ? base + w2 : w2;
        c.rpt    = (w1[15:13] == OP_ALARM) && w1[7];
        c.bc     = w1[3:0];
        c.en_wr  = (w1[15:13] == OP_AT_EN);
        c.en_val = w1[7];
        return c;
    endfunction

    // Capture state
    cap_state_t  state_a, state_b;
    logic [15:0] w1_a, w1_b;

    // Mode register
    logic       active;
    logic [1:0] at_perm, bc_perm;

    // BC and AT state
    logic [15:0]       bc_cnt  [NUM_BC];
    logic [1:0]        bc_rate [NUM_BC];
    logic [NUM_BC-1:0] bc_en;
    logic [15:0]       at_tgt  [NUM_AT];
    logic [3:0]        at_bc   [NUM_AT];
    logic [NUM_AT-1:0] at_rpt, at_armed, at_en;

    // Decode of the executing instructions
    logic       exec_a, exec_b, rej_a, rej_b, ok_a, ok_b, start_a, start_b;
    logic [2:0] op_a, op_b;

    assign exec_a  = (state_a == WORD2);
    assign exec_b  = (state_b == WORD2);
    assign op_a    = w1_a[15:13];
    assign op_b    = w1_b[15:13];
    assign rej_a   = rejects(w1_a, active, at_perm[1], bc_perm[1]);
    assign rej_b   = rejects(w1_b, active, at_perm[0], bc_perm[0]);
    assign ok_a    = exec_a && !rej_a;
    assign ok_b    = exec_b && !rej_b;
    assign start_a = (state_a == IDLE) && req && (ctrlA[15:13] != OP_NOP);
    assign start_b = (state_b == IDLE) && req && (ctrlB[15:13] != OP_NOP);

    // Per-BC writes, increments and next values
    bc_cmd_t     bc_cmd  [NUM_BC];
    logic [15:0] bc_inc  [NUM_BC];
    logic [15:0] bc_next [NUM_BC];
    logic [NUM_BC-1:0] bc_adv;

    always_comb begin
        for (int j = 0; j < NUM_BC; j++) begin
            // NOTE: every always_comb output gets a default on every path, so no latch is inferred.
            bc_cmd[j] = '0;
            if (ok_a && is_bc_op(op_a) && (w1_a[12:9] == 4'(j)))
                bc_cmd[j] = bc_cmd_of(w1_a, ctrlA);
            else if (ok_b && is_bc_op(op_b) && (w1_b[12:9] == 4'(j)))
                bc_cmd[j] = bc_cmd_of(w1_b, ctrlB);
            bc_inc[j]  = 16'd1 << bc_rate[j];
            // A load replaces this cycle's increment and is not a crossing.
            bc_adv[j]  = active && bc_en[j] && !bc_cmd[j].load;
            bc_next[j] = bc_cmd[j].load ? bc_cmd[j].value
                       : (bc_adv[j] ? bc_cnt[j] + bc_inc[j] : bc_cnt[j]);
        end
    end

    // Per-AT writes and expiry detection
    at_cmd_t     at_cmd  [NUM_AT];
    logic [15:0] at_diff [NUM_AT];
    logic [NUM_AT-1:0] at_hit;

    always_comb begin
        for (int i = 0; i < NUM_AT; i++) begin
            at_cmd[i] = '0;
            if (ok_a && is_at_op(op_a) && (w1_a[12:8] == 5'(i)))
                at_cmd[i] = at_cmd_of(w1_a, ctrlA, bc_next[w1_a[3:0]]);
            else if (ok_b && is_at_op(op_b) && (w1_b[12:8] == 5'(i)))
                at_cmd[i] = at_cmd_of(w1_b, ctrlB, bc_next[w1_b[3:0]]);
            // The target lies in (old, old + inc] exactly when
            // (target - old) mod 2^16 is in [1, inc]. This also covers wrap.
            at_diff[i] = at_tgt[i] - bc_cnt[at_bc[i]];
            at_hit[i]  = at_armed[i] && at_en[i] && bc_adv[at_bc[i]]
                      && (at_diff[i] != 16'd0) && (at_diff[i] <= bc_inc[at_bc[i]])
                      && !at_cmd[i].cfg;
        end
    end

    // Capture FSMs, ready and reject flags
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
            state_a <= IDLE;
            state_b <= IDLE;
            w1_a    <= '0;
            w1_b    <= '0;
            ready   <= 1'b1;
            stat    <= 2'b00;
        end else begin
            case (state_a)
                IDLE:    if (start_a) begin state_a <= WORD2; w1_a <= ctrlA; end
                default: state_a <= IDLE;
            endcase
            case (state_b)
                IDLE:    if (start_b) begin state_b <= WORD2; w1_b <= ctrlB; end
                default: state_b <= IDLE;
            endcase
            // WORD2 always returns to IDLE, so only a new start leaves a client busy.
            ready <= !start_a && !start_b;
            stat  <= {exec_a && rej_a, exec_b && rej_b};
        end
    end

    // BC, AT and mode state
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the BC/AT arrays are architectural state with defined reset values, so they are reset element by element rather than left as uninitialised RAM.
            for (int j = 0; j < NUM_BC; j++) begin
                bc_cnt[j]  <= '0;
                bc_rate[j] <= 2'b00;
            end
            for (int i = 0; i < NUM_AT; i++) begin
                at_tgt[i] <= '0;
                at_bc[i]  <= '0;
            end
            bc_en    <= '1;
            at_rpt   <= '0;
            at_armed <= '0;
            at_en    <= '1;
            data     <= '0;
            active   <= 1'b1;
            at_perm  <= 2'b11;
            bc_perm  <= 2'b11;
        end else begin
            for (int j = 0; j < NUM_BC; j++) begin
                bc_cnt[j] <= bc_next[j];
                if (bc_cmd[j].load)  bc_rate[j] <= bc_cmd[j].rate;
                if (bc_cmd[j].en_wr) bc_en[j]   <= bc_cmd[j].en_val;
            end
            for (int i = 0; i < NUM_AT; i++) begin
                data[i] <= at_hit[i];
                if (at_cmd[i].cfg) begin
                    at_tgt[i]   <= at_cmd[i].target;
                    at_rpt[i]   <= at_cmd[i].rpt;
                    at_bc[i]    <= at_cmd[i].bc;
                    at_armed[i] <= 1'b1;
                    at_en[i]    <= 1'b1;
                end else begin
                    if (at_hit[i] && !at_rpt[i]) at_armed[i] <= 1'b0;
                    if (at_cmd[i].en_wr)         at_en[i]    <= at_cmd[i].en_val;
                end
            end
            if (ok_a && (op_a == OP_MODE))
                {active, at_perm, bc_perm} <= w1_a[12:8];
            else if (ok_b && (op_b == OP_MODE))
                {active, at_perm, bc_perm} <= w1_b[12:8];
        end
    end

endmodule

// File: tb/tb_ats21.sv
// Directed self-checking bench for ats21. Inputs change 1 ns after each
// rising edge, and outputs are read at that same point.
module tb_ats21;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [15:0] ctrlA, ctrlB;
    logic        ready;
    logic [1:0]  stat;
    logic [23:0] data;

    int n_checks = 0;
    int n_fail   = 0;

    ats21 dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .ctrlA (ctrlA),
        .ctrlB (ctrlB),
        .ready (ready),
        .stat  (stat),
        .data  (data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Instruction word builders
    function automatic logic [15:0] w_set_bc(input logic [3:0] id, input logic [1:0] rate);
        return {3'b001, id, 1'b0, rate, 6'b0};
    endfunction
    function automatic logic [15:0] w_bc_en(input logic [3:0] id, input logic en);
        return {3'b010, id, 1'b0, en, 7'b0};
    endfunction
    function automatic logic [15:0] w_mode(input logic act, input logic [1:0] atp, input logic [1:0] bcp);
        return {3'b011, act, atp, bcp, 8'b0};
    endfunction
    function automatic logic [15:0] w_alarm(input logic [4:0] at, input logic rpt, input logic [3:0] bc);
        return {3'b101, at, rpt, 3'b0, bc};
    endfunction
    function automatic logic [15:0] w_cdown(input logic [4:0] at, input logic [3:0] bc);
        return {3'b110, at, 1'b0, 3'b0, bc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Both clients start on the same req cycle.
    task automatic send_sim(input string tag, input logic [15:0] a1, input logic [15:0] a2,
                            input logic [15:0] b1, input logic [15:0] b2, input logic [1:0] exp_stat);
        req = 1'b1; ctrlA = a1; ctrlB = b1;
        step();
        check({tag, "_ready_busy"}, 32'(ready), 32'h0);
        req = 1'b0; ctrlA = a2; ctrlB = b2;
        step();
        check({tag, "_ready_done"}, 32'(ready), 32'h1);
        check({tag, "_stat"}, 32'(stat), 32'(exp_stat));
    endtask

    // Step until any data bit is high, for at most max_cycles edges.
    // n = edges waited, or -1 if no pulse was seen.
    task automatic wait_pulse(input int max_cycles, output int n, output logic [23:0] d);
        n = -1;
        d = '0;
        for (int k = 1; k <= max_cycles; k++) begin
            step();
            if (data !== 24'h0) begin
                n = k;
                d = data;
                break;
            end
        end
    endtask

    int          n;
    logic [23:0] d;

    initial begin
        reset = 1'b1; req = 1'b0; ctrlA = '0; ctrlB = '0;
        repeat (4) step();
        reset = 1'b0;
        check("reset_data",  32'(data),  32'h0);
        check("reset_stat",  32'(stat),  32'h0);
        check("reset_ready", 32'(ready), 32'h1);

        // Simultaneous: BC0 rate 1 from 0, BC1 rate 2 from 0 (edge E0).
        send_sim("sim_bc", w_set_bc(4'd0, 2'd0), 16'd0, w_set_bc(4'd1, 2'd1), 16'd0, 2'b00);
        // Alarms at BC0 = 10 (AT2) and BC1 = 20 (AT3). Both are reached at E0+10.
        send_sim("sim_alarm", w_alarm(5'd2, 1'b0, 4'd0), 16'd10,
                              w_alarm(5'd3, 1'b0, 4'd1), 16'd20, 2'b00);
        check("bc_quiet_2", 32'(data), 32'h0);
        for (int k = 3; k < 10; k++) begin
            step();
            check("bc_quiet", 32'(data), 32'h0);
        end
        step();
        check("bc0_10_bc1_20", 32'(data), 32'h00000C);
        step();
        check("bc_pulse_one_cycle", 32'(data), 32'h0);

        // Staggered: A sets repeat alarm AT0 @50 on BC0, then B sets one-shot AT23 @50.
        req = 1'b1; ctrlA = w_alarm(5'd0, 1'b1, 4'd0); ctrlB = 16'h0;
        step();
        check("stag_ready_a", 32'(ready), 32'h0);
        ctrlA = 16'd50; ctrlB = w_alarm(5'd23, 1'b0, 4'd0);
        step();
        check("stag_ready_b", 32'(ready), 32'h0);
        check("stag_stat_a", 32'(stat), 32'h0);
        req = 1'b0; ctrlA = 16'h0; ctrlB = 16'd50;
        step();
        check("stag_ready_done", 32'(ready), 32'h1);
        check("stag_stat_b", 32'(stat), 32'h0);
        // BC0 reads 14 here and reaches 50 after 36 more edges.
        wait_pulse(60, n, d);
        check("stag_delay", 32'(n), 32'd36);
        check("stag_bits", 32'(d), 32'h800001);
        step();
        check("stag_one_cycle", 32'(data), 32'h0);

        // Reload BC0 near the top. The wrap past 50 takes 0x10 + 50 = 66 edges.
        send_sim("reload", w_set_bc(4'd0, 2'd0), 16'hFFF0, 16'h0, 16'h0, 2'b00);
        wait_pulse(100, n, d);
        check("wrap_delay", 32'(n), 32'd66);
        check("wrap_repeat_only", 32'(d), 32'h000001);
        step();
        check("wrap_one_cycle", 32'(data), 32'h0);

        // Countdown on AT1, BC2 at rate 1, interval 10, while B issues a Nop.
        send_sim("cdown", w_cdown(5'd1, 4'd2), 16'd10, 16'h0, 16'h0, 2'b00);
        wait_pulse(30, n, d);
        check("cdown_delay", 32'(n), 32'd10);
        check("cdown_bit", 32'(d), 32'h000002);
        step();
        check("cdown_one_cycle", 32'(data), 32'h0);
        wait_pulse(40, n, d);
        check("cdown_no_repeat", 32'(n), 32'hFFFFFFFF);

        // Permissions: AT ops allowed only for B.
        send_sim("perm_mode", w_mode(1'b1, 2'b01, 2'b11), 16'h0, 16'h0, 16'h0, 2'b00);
        send_sim("perm_rej_a", w_cdown(5'd4, 4'd2), 16'd5, 16'h0, 16'h0, 2'b10);
        step();
        check("perm_stat_clear", 32'(stat), 32'h0);
        wait_pulse(20, n, d);
        check("perm_no_effect", 32'(n), 32'hFFFFFFFF);
        send_sim("id24_rej_b", 16'h0, 16'h0, w_alarm(5'd24, 1'b0, 4'd0), 16'd100, 2'b01);
        step();
        check("id24_stat_clear", 32'(stat), 32'h0);
        send_sim("perm_restore", w_mode(1'b1, 2'b11, 2'b11), 16'h0, 16'h0, 16'h0, 2'b00);

        // Freeze: AT5 counts 20 on BC2. Five increments happen before the
        // freeze, no pulse while inactive, and the last 15 follow the resume.
        send_sim("frz_cdown", w_cdown(5'd5, 4'd2), 16'd20, 16'h0, 16'h0, 2'b00);
        repeat (3) step();
        send_sim("frz_off", w_mode(1'b0, 2'b11, 2'b11), 16'h0, 16'h0, 16'h0, 2'b00);
        send_sim("frz_rej", w_bc_en(4'd2, 1'b1), 16'h0, 16'h0, 16'h0, 2'b10);
        wait_pulse(30, n, d);
        check("frz_no_pulse", 32'(n), 32'hFFFFFFFF);
        send_sim("frz_on", w_mode(1'b1, 2'b11, 2'b11), 16'h0, 16'h0, 16'h0, 2'b00);
        wait_pulse(40, n, d);
        check("frz_resume_delay", 32'(n), 32'd15);
        check("frz_resume_bit", 32'(d), 32'h000020);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
